// File: rtl/led_pwm_fader.sv
// Purpose : per-LED brightness (instant attack, timed linear fade) rendered as glitch-free PWM.
// Latency : ivled -> level 2 clocks; level -> owvled at the next PWM period start + 1 register.
// Backpres: none; free-running stage with no handshake, ienable=0 freezes all state and blanks outputs.
//
// Ports:
//   iclk     system clock
//   irst     synchronous reset, active-high
//   ivled    [NUM_LED] LED pattern from the LED FSM (same clock domain), 1 = lit
//   ienable  1 = run, 0 = hold levels/counters and force owvled/otick low
//   owvled   [NUM_LED] registered PWM drive, 1 = LED on
//   otick    registered one-cycle decay-tick pulse
//
// Optional feature: define LED_PWM_GAMMA_EN to apply a square-law brightness
// map to each level before it reaches the PWM comparator; the default build is
// a linear map with no multiplier.

module led_pwm_fader #(
    parameter int NUM_LED    = 8,
    parameter int PWM_BITS   = 8,
    parameter int DECAY_DIV  = 46875,
    parameter int DECAY_STEP = 1
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic [NUM_LED-1:0] ivled,
    input  logic               ienable,
    output logic [NUM_LED-1:0] owvled,
    output logic               otick
);

    // A one-clock divider still needs a 1-bit counter to keep the logic legal.
    localparam int TICK_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

    localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(DECAY_DIV - 1);
    localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(DECAY_STEP);
    localparam int                  STEP_I    = DECAY_STEP;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_LED-1:0]  r_vled;
    logic [TICK_W-1:0]   tick_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] level [NUM_LED];
    logic [PWM_BITS-1:0] duty  [NUM_LED];

    // Period boundary: the shadow duty registers load only here, so a
    // running period is never cut short by a level change.
    logic period_end;
    assign period_end = (pwm_cnt == MAX);

    // ------------------------------------------------------------------
    // Brightness map from fade level to PWM duty
    // ------------------------------------------------------------------
    function automatic logic [PWM_BITS-1:0] level_map(input logic [PWM_BITS-1:0] lvl);
`ifdef LED_PWM_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, lvl};
        // Full scale is pinned so a lit LED stays constant high.
        if (lvl == MAX) begin
            return MAX;
        end
        return sq[2*PWM_BITS-1:PWM_BITS];
`else
        return lvl;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Input register: source is the same clock domain, one stage suffices.
    // ------------------------------------------------------------------
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_vled <= '0;
        end else begin
            r_vled <= ivled;
        end
    end

    // ------------------------------------------------------------------
    // Decay-tick divider. otick is registered, so it is high on the cycle
    // after the counter reaches its last value; the level update below
    // consumes that registered pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge iclk) begin
        if (irst) begin
            tick_cnt <= '0;
            otick    <= 1'b0;
        end else if (ienable) begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            otick <= (tick_cnt == TICK_LAST);
        end else begin
            otick <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // PWM period counter, free-running and wrapping naturally at MAX.
    // ------------------------------------------------------------------
    always_ff @(posedge iclk) begin
        if (irst) begin
            pwm_cnt <= '0;
        end else if (ienable) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel level: a lit pattern bit wins over a same-cycle decay
    // tick; decay saturates at zero instead of wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge iclk) begin
        if (irst) begin
            for (int i = 0; i < NUM_LED; i++) begin
                level[i] <= '0;
            end
        end else if (ienable) begin
            for (int i = 0; i < NUM_LED; i++) begin
                if (r_vled[i]) begin
                    level[i] <= MAX;
                end else if (otick) begin
                    if (int'(level[i]) > STEP_I) begin
                        level[i] <= level[i] - STEP;
                    end else begin
                        level[i] <= '0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Duty shadow: samples the level as it stands before any same-cycle
    // update, so a change at the boundary shows up one period later.
    // ------------------------------------------------------------------
    always_ff @(posedge iclk) begin
        if (irst) begin
            for (int i = 0; i < NUM_LED; i++) begin
                duty[i] <= '0;
            end
        end else if (ienable && period_end) begin
            for (int i = 0; i < NUM_LED; i++) begin
                duty[i] <= level_map(level[i]);
            end
        end
    end

    // ------------------------------------------------------------------
    // PWM comparator. Full duty is forced high explicitly because the plain
    // compare would drop the output for the pwm_cnt==MAX clock.
    // ------------------------------------------------------------------
    always_ff @(posedge iclk) begin
        if (irst) begin
            owvled <= '0;
        end else if (ienable) begin
            for (int i = 0; i < NUM_LED; i++) begin
                owvled[i] <= (duty[i] == MAX) | (pwm_cnt < duty[i]);
            end
        end else begin
            owvled <= '0;
        end
    end

endmodule
